stopwatch_timebase: RTL

Downstream consumer of the stopwatch mode FSM output. Takes the current mode (state_t: IDLE, RUNNING, CLEAR) and maintains the elapsed time as six BCD digits, MM:SS.cc (minutes, seconds, centiseconds). An internal prescaler divides clk down to a centisecond tick. The BCD digits feed the seven-segment display driver directly.

---
 rtl/stopwatch_timebase_if.sv | 42 ++++
 rtl/stopwatch_timebase.sv | 87 ++++++++
 2 files changed

// File: rtl/stopwatch_timebase_if.sv
// Stopwatch mode type and the mode/display bundle between the mode FSM,
// the timebase and the seven-segment driver.
//   state            : current stopwatch mode (IDLE, RUNNING, CLEAR)
//   cs_ones..m_tens  : elapsed time MM:SS.cc as six BCD digits
//   running          : registered (state == RUNNING)
//   rollover         : one-cycle pulse on the 59:59.99 -> 00:00.00 wrap
package stopwatch_pkg;
    // Encoding 2'b11 is unused; the timebase treats it as IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        CLEAR   = 2'd2
    } state_t;
endpackage

interface stopwatch_timebase_if;
    import stopwatch_pkg::*;

    state_t     state;
    logic [3:0] cs_ones;
    logic [3:0] cs_tens;
    logic [3:0] s_ones;
    logic [3:0] s_tens;
    logic [3:0] m_ones;
    logic [3:0] m_tens;
    logic       running;
    logic       rollover;

    // master: mode source / display consumer side
    modport master (
        output state,
        input  cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens,
        input  running, rollover
    );

    // slave: the timebase itself
    modport slave (
        input  state,
        output cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens,
        output running, rollover
    );
endinterface

// File: rtl/stopwatch_timebase.sv
// Stopwatch timebase: divides clk down to a centisecond tick and keeps the
// elapsed time as six BCD digits MM:SS.cc, driven by the current mode.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset, clears all state
//   bus  : stopwatch_timebase_if.slave - state in; digits, running and
//          rollover out (all registered)
module stopwatch_timebase
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    stopwatch_timebase_if.slave   bus
);
    localparam int             PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PMAX = PW'(TICK_DIV - 1);

    // Per-digit wrap limits, index 0 = cs_ones ... 5 = m_tens.
    localparam logic [5:0][3:0] LIM = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

    logic [PW-1:0]    presc_q, presc_d;
    logic [5:0][3:0]  dig_q, dig_d;
    logic             running_q;
    logic             rollover_q, rollover_d;
    logic             carry;

    always_comb begin
        presc_d    = presc_q;
        dig_d      = dig_q;
        rollover_d = 1'b0;
        carry      = 1'b0;
        case (bus.state)
            CLEAR: begin
                // Clearing wins over any tick due on this edge.
                presc_d = '0;
                dig_d   = '0;
            end
            RUNNING: begin
                if (presc_q == PMAX) begin
                    presc_d = '0;
                    // Ripple the increment through all digits in one cycle;
                    // a carry out of m_tens is the full wrap.
                    carry = 1'b1;
                    for (int i = 0; i < 6; i++) begin
                        if (carry) begin
                            if (dig_q[i] == LIM[i]) begin
                                dig_d[i] = 4'd0;
                            end else begin
                                dig_d[i] = dig_q[i] + 4'd1;
                                carry    = 1'b0;
                            end
                        end
                    end
                    rollover_d = carry;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            // IDLE and the unused encoding pause: prescaler fraction kept.
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            dig_q      <= '0;
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            dig_q      <= dig_d;
            running_q  <= (bus.state == RUNNING);
            rollover_q <= rollover_d;
        end
    end

    assign bus.cs_ones  = dig_q[0];
    assign bus.cs_tens  = dig_q[1];
    assign bus.s_ones   = dig_q[2];
    assign bus.s_tens   = dig_q[3];
    assign bus.m_ones   = dig_q[4];
    assign bus.m_tens   = dig_q[5];
    assign bus.running  = running_q;
    assign bus.rollover = rollover_q;
endmodule
